// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the 6502-style core front end.
package cpu_pkg;

  localparam int unsigned OP_W = 8;
  localparam int unsigned ST_W = 4;

  // Sequencer states
  localparam logic [ST_W-1:0] ST_FETCH = 4'd0;
  localparam logic [ST_W-1:0] ST_ZP    = 4'd1;
  localparam logic [ST_W-1:0] ST_IDX   = 4'd2;
  localparam logic [ST_W-1:0] ST_ABS_L = 4'd3;
  localparam logic [ST_W-1:0] ST_ABS_H = 4'd4;
  localparam logic [ST_W-1:0] ST_PTR_L = 4'd5;
  localparam logic [ST_W-1:0] ST_PTR_H = 4'd6;
  localparam logic [ST_W-1:0] ST_FIX   = 4'd7;
  localparam logic [ST_W-1:0] ST_EXEC  = 4'd8;

  typedef enum logic [3:0] {
    MODE_IMP  = 4'd0,
    MODE_IMM  = 4'd1,
    MODE_ZP   = 4'd2,
    MODE_ZPX  = 4'd3,
    MODE_ABS  = 4'd4,
    MODE_ABSX = 4'd5,
    MODE_ABSY = 4'd6,
    MODE_INDX = 4'd7,
    MODE_INDY = 4'd8
  } mode_t;

  // Opcode field constants
  localparam logic [2:0] AAA_STORE = 3'b100;
  localparam logic [1:0] CC_GRP0   = 2'b00;
  localparam logic [1:0] CC_GRP1   = 2'b01;
  localparam logic [1:0] CC_GRP2   = 2'b10;
  localparam logic [1:0] CC_GRP3   = 2'b11;

  // ALU operation codes (group-1 aaa field)
  localparam logic [2:0] ALU_ORA = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_EOR = 3'd2;
  localparam logic [2:0] ALU_ADC = 3'd3;
  localparam logic [2:0] ALU_STA = 3'd4;
  localparam logic [2:0] ALU_LDA = 3'd5;
  localparam logic [2:0] ALU_CMP = 3'd6;
  localparam logic [2:0] ALU_SBC = 3'd7;

  // Modes whose effective address goes through the low-byte index adder
  function automatic logic mode_indexed(input mode_t m);
    return (m == MODE_ABSX) || (m == MODE_ABSY) || (m == MODE_INDY);
  endfunction

  // Modes whose EXEC cycle accesses memory at the effective address
  function automatic logic mode_mem(input mode_t m);
    return (m != MODE_IMP) && (m != MODE_IMM);
  endfunction

endpackage

// File: rtl/cpu_mode_decode.sv
// Maps an opcode's {bbb,cc} fields to an addressing mode, plus the store flag.
module cpu_mode_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output mode_t           mode_c,
  output logic            is_store_c
);

  logic [2:0] bbb;
  logic [1:0] cc;

  assign bbb        = opcode[4:2];
  assign cc         = opcode[1:0];
  assign is_store_c = (opcode[7:5] == AAA_STORE);

  always_comb begin
    mode_c = MODE_IMP;
    if (cc == CC_GRP1) begin
      case (bbb)
        3'b000:  mode_c = MODE_INDX;
        3'b001:  mode_c = MODE_ZP;
        3'b010:  mode_c = MODE_IMM;
        3'b011:  mode_c = MODE_ABS;
        3'b100:  mode_c = MODE_INDY;
        3'b101:  mode_c = MODE_ZPX;
        3'b110:  mode_c = MODE_ABSY;
        default: mode_c = MODE_ABSX;
      endcase
    end else if (cc != CC_GRP3) begin
      // groups 0 and 2 share one table; unlisted rows are implied
      case (bbb)
        3'b000:  mode_c = MODE_IMM;
        3'b001:  mode_c = MODE_ZP;
        3'b011:  mode_c = MODE_ABS;
        3'b101:  mode_c = MODE_ZPX;
        3'b111:  mode_c = MODE_ABSX;
        default: mode_c = MODE_IMP;
      endcase
    end
  end

endmodule

// File: rtl/cpu_addr_seq.sv
// Instruction-fetch and addressing-mode sequencer: owns PC/IR and walks
// each operand mode cycle by cycle against a combinational-read bus.
module cpu_addr_seq
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ready,
  input  logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] x_idx,
  input  logic [DATA_W-1:0] y_idx,
  input  logic [DATA_W-1:0] st_data,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] addr,
  output logic              write,
  output logic [DATA_W-1:0] d_out,
  output logic              sync,
  output logic [OP_W-1:0]   ir,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_data,
  output logic [ADDR_W-1:0] ea
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] zp_q, zp_d;
  logic [DATA_W-1:0] adl_q, adl_d;
  logic [DATA_W-1:0] adh_q, adh_d;
  logic              cry_q, cry_d;

  logic [OP_W-1:0]   op_sel;
  mode_t             mode;
  logic              is_store;
  logic [DATA_W-1:0] idx;
  logic [DATA_W:0]   idx_sum;
  logic [DATA_W-1:0] zp_sum;
  logic [DATA_W-1:0] zp_inc;
  logic [ADDR_W-1:0] ea_w;
  logic [ADDR_W-1:0] pc_inc;
  logic              fix_need;

  // In FETCH the opcode is still on the bus; afterwards it lives in IR
  assign op_sel = (state_q == ST_FETCH) ? d_in : ir_q;

  cpu_mode_decode u_decode (
    .opcode     (op_sel),
    .mode_c     (mode),
    .is_store_c (is_store)
  );

  always_comb begin
    idx = '0;
    case (mode)
      MODE_ABSX:            idx = x_idx;
      MODE_ABSY, MODE_INDY: idx = y_idx;
      default:              idx = '0;
    endcase
  end

  assign idx_sum  = {1'b0, adl_q} + {1'b0, idx};
  assign zp_sum   = zp_q + x_idx;
  assign zp_inc   = zp_q + DATA_W'(1);
  assign ea_w     = ADDR_W'({adh_q, adl_q});
  assign pc_inc   = pc_q + ADDR_W'(1);
  // Stores always take the fix-up cycle so the bus never sees a wrong-page write
  assign fix_need = mode_indexed(mode) && (idx_sum[DATA_W] || is_store);

  assign d_out = st_data;
  assign ir    = ir_q;
  assign ea    = ea_w;
  assign sync  = (state_q == ST_FETCH);

  // Bus address and EXEC-cycle strobes
  always_comb begin
    addr     = pc_q;
    op_valid = 1'b0;
    write    = 1'b0;
    op_data  = '0;
    case (state_q)
      ST_PTR_L: addr = ADDR_W'(zp_q);
      ST_PTR_H: addr = ADDR_W'(zp_inc);
      ST_EXEC: begin
        if (mode_mem(mode)) addr = ea_w;
        op_valid = ready;
        if (ready) begin
          op_data = (mode == MODE_IMP) ? '0 : d_in;
          write   = is_store && mode_mem(mode);
        end
      end
      default: addr = pc_q;
    endcase
  end

  // Next state; nothing advances while the bus is stalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zp_d    = zp_q;
    adl_d   = adl_q;
    adh_d   = adh_q;
    cry_d   = cry_q;
    if (ready) begin
      case (state_q)
        ST_FETCH: begin
          ir_d = d_in;
          pc_d = pc_inc;
          case (mode)
            MODE_IMP, MODE_IMM:                          state_d = ST_EXEC;
            MODE_ZP, MODE_ZPX, MODE_INDX, MODE_INDY:     state_d = ST_ZP;
            default:                                     state_d = ST_ABS_L;
          endcase
        end
        ST_ZP: begin
          zp_d  = d_in;
          adl_d = d_in;
          adh_d = '0;
          pc_d  = pc_inc;
          case (mode)
            MODE_ZPX, MODE_INDX: state_d = ST_IDX;
            MODE_INDY:           state_d = ST_PTR_L;
            default:             state_d = ST_EXEC;
          endcase
        end
        ST_IDX: begin
          zp_d    = zp_sum;
          adl_d   = zp_sum;
          adh_d   = '0;
          state_d = (mode == MODE_INDX) ? ST_PTR_L : ST_EXEC;
        end
        ST_ABS_L: begin
          adl_d   = d_in;
          pc_d    = pc_inc;
          state_d = ST_ABS_H;
        end
        ST_ABS_H: begin
          adh_d          = d_in;
          {cry_d, adl_d} = idx_sum;
          pc_d           = pc_inc;
          state_d        = fix_need ? ST_FIX : ST_EXEC;
        end
        ST_PTR_L: begin
          adl_d   = d_in;
          state_d = ST_PTR_H;
        end
        ST_PTR_H: begin
          adh_d          = d_in;
          {cry_d, adl_d} = idx_sum;
          state_d        = fix_need ? ST_FIX : ST_EXEC;
        end
        ST_FIX: begin
          adh_d   = adh_q + DATA_W'(cry_q);
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (mode == MODE_IMM) pc_d = pc_inc;
          if (pc_load)          pc_d = pc_target;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      zp_q    <= '0;
      adl_q   <= '0;
      adh_q   <= '0;
      cry_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zp_q    <= zp_d;
      adl_q   <= adl_d;
      adh_q   <= adh_d;
      cry_q   <= cry_d;
    end
  end

endmodule

// File: tb/tb_cpu_addr_seq.sv
// Self-checking bench for cpu_addr_seq: per-instruction cycle-list model
// compared every cycle, plus directed literal checks and random traffic.
module tb_cpu_addr_seq;

  localparam int K_FETCH = 0;
  localparam int K_OPER  = 1;
  localparam int K_IDX   = 2;
  localparam int K_PTRL  = 3;
  localparam int K_PTRH  = 4;
  localparam int K_FIX   = 5;
  localparam int K_EXEC  = 6;
  localparam int K_ABSH  = 7;
  localparam int K_NONE  = 15;

  localparam int M_IMP = 0, M_IMM = 1, M_ZP = 2, M_ZPX = 3, M_ABS = 4,
                 M_ABSX = 5, M_ABSY = 6, M_INDX = 7, M_INDY = 8;

  typedef struct packed {
    logic [3:0]  kind;
    logic [15:0] addr;
    logic        addr_chk;
    logic        sync;
    logic        exec;
    logic        ea_chk;
    logic        write;
    logic [7:0]  op_data;
    logic [15:0] ea;
    logic [7:0]  ir;
    logic [7:0]  wdata;
  } rec_t;

  logic        clk;
  logic        reset_n;
  logic        ready;
  logic [7:0]  d_in, x_idx, y_idx, st_data;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [15:0] addr;
  logic        write;
  logic [7:0]  d_out;
  logic        sync;
  logic [7:0]  ir;
  logic        op_valid;
  logic [7:0]  op_data;
  logic [15:0] ea;

  logic [7:0]  mem [0:65535];
  rec_t        q[$];
  logic [15:0] model_pc;
  logic [7:0]  prev_ir;
  int          n_cmp, n_err;
  int          lat, wr_cnt;
  logic [15:0] ea_obs, wr_addr, ptrl_obs, ptrh_obs;
  logic [7:0]  wr_data;

  assign d_in = mem[addr];

  cpu_addr_seq #(.ADDR_W(16), .DATA_W(8), .PC_RESET(16'h8000)) dut (
    .clk(clk), .reset_n(reset_n), .ready(ready), .d_in(d_in),
    .x_idx(x_idx), .y_idx(y_idx), .st_data(st_data),
    .pc_load(pc_load), .pc_target(pc_target),
    .addr(addr), .write(write), .d_out(d_out), .sync(sync), .ir(ir),
    .op_valid(op_valid), .op_data(op_data), .ea(ea)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int ref_mode(input logic [7:0] op);
    int t1 [8] = '{M_INDX, M_ZP, M_IMM, M_ABS, M_INDY, M_ZPX, M_ABSY, M_ABSX};
    int t0 [8] = '{M_IMM, M_ZP, M_IMP, M_ABS, M_IMP, M_ZPX, M_IMP, M_ABSX};
    if (op[1:0] == 2'b01) return t1[op[4:2]];
    if (op[1:0] == 2'b11) return M_IMP;
    return t0[op[4:2]];
  endfunction

  function automatic rec_t mk(input int kind, input logic [15:0] a, input bit chk_a,
                              input logic [7:0] op);
    rec_t r;
    r = '0;
    r.kind     = 4'(kind);
    r.addr     = a;
    r.addr_chk = chk_a;
    r.sync     = (kind == K_FETCH);
    r.exec     = (kind == K_EXEC);
    r.ir       = (kind == K_FETCH) ? prev_ir : op;
    return r;
  endfunction

  // Expected cycle list for the instruction at model_pc
  task automatic build();
    logic [15:0] pc, p1, p2, e, base;
    logic [7:0]  op, b1, zp, zp1, i;
    int          m;
    bit          st, fix, memm;
    rec_t        r;
    pc = model_pc;
    op = mem[pc];
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    b1 = mem[p1];
    m  = ref_mode(op);
    st = (op[7:5] == 3'b100);
    q.push_back(mk(K_FETCH, pc, 1'b1, op));
    memm = 1'b1;
    e    = '0;
    case (m)
      M_IMM: begin
        memm = 1'b0;
        r = mk(K_EXEC, p1, 1'b1, op);
        r.op_data = b1;
        q.push_back(r);
        model_pc = p2;
      end
      M_IMP: begin
        memm = 1'b0;
        r = mk(K_EXEC, p1, 1'b1, op);
        q.push_back(r);
        model_pc = p1;
      end
      M_ZP, M_ZPX: begin
        q.push_back(mk(K_OPER, p1, 1'b1, op));
        zp = b1;
        if (m == M_ZPX) begin
          q.push_back(mk(K_IDX, 16'h0, 1'b0, op));
          zp = b1 + x_idx;
        end
        e = {8'h00, zp};
        model_pc = p2;
      end
      M_ABS, M_ABSX, M_ABSY: begin
        q.push_back(mk(K_OPER, p1, 1'b1, op));
        q.push_back(mk(K_ABSH, p2, 1'b1, op));
        base = {mem[p2], b1};
        i    = (m == M_ABSX) ? x_idx : (m == M_ABSY) ? y_idx : 8'h00;
        fix  = (m != M_ABS) && (((int'(b1) + int'(i)) > 255) || st);
        if (fix) q.push_back(mk(K_FIX, 16'h0, 1'b0, op));
        e = base + {8'h00, i};
        model_pc = pc + 16'd3;
      end
      M_INDX: begin
        q.push_back(mk(K_OPER, p1, 1'b1, op));
        q.push_back(mk(K_IDX, 16'h0, 1'b0, op));
        zp  = b1 + x_idx;
        zp1 = zp + 8'd1;
        q.push_back(mk(K_PTRL, {8'h00, zp}, 1'b1, op));
        q.push_back(mk(K_PTRH, {8'h00, zp1}, 1'b1, op));
        e = {mem[{8'h00, zp1}], mem[{8'h00, zp}]};
        model_pc = p2;
      end
      default: begin
        q.push_back(mk(K_OPER, p1, 1'b1, op));
        zp1 = b1 + 8'd1;
        q.push_back(mk(K_PTRL, {8'h00, b1}, 1'b1, op));
        q.push_back(mk(K_PTRH, {8'h00, zp1}, 1'b1, op));
        base = {mem[{8'h00, zp1}], mem[{8'h00, b1}]};
        fix  = ((int'(base[7:0]) + int'(y_idx)) > 255) || st;
        if (fix) q.push_back(mk(K_FIX, 16'h0, 1'b0, op));
        e = base + {8'h00, y_idx};
        model_pc = p2;
      end
    endcase
    if (memm) begin
      r = mk(K_EXEC, e, 1'b1, op);
      r.ea_chk  = 1'b1;
      r.ea      = e;
      r.op_data = mem[e];
      r.write   = st;
      r.wdata   = st_data;
      q.push_back(r);
    end
    prev_ir = op;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model after posedge
  task automatic step(input bit rdy, input bit pl, input logic [15:0] tgt);
    rec_t r;
    if (q.size() == 0) build();
    r = q[0];
    ready = rdy; pc_load = pl; pc_target = tgt;
    @(negedge clk);
    chk("sync", 32'(sync), 32'(r.sync));
    if (r.addr_chk) chk("addr", 32'(addr), 32'(r.addr));
    chk("op_valid", 32'(op_valid), 32'(r.exec & rdy));
    chk("write", 32'(write), 32'(r.write & rdy));
    chk("ir", 32'(ir), 32'(r.ir));
    if (r.exec && rdy) begin
      chk("op_data", 32'(op_data), 32'(r.op_data));
      if (r.ea_chk) chk("ea", 32'(ea), 32'(r.ea));
      if (r.write) chk("d_out", 32'(d_out), 32'(r.wdata));
      ea_obs = ea;
    end
    if (write) begin
      wr_cnt++;
      wr_addr = addr;
      wr_data = d_out;
    end
    if (rdy && r.kind == 4'(K_PTRL)) ptrl_obs = addr;
    if (rdy && r.kind == 4'(K_PTRH)) ptrh_obs = addr;
    @(posedge clk);
    #1;
    if (rdy) begin
      if (r.exec && pl) model_pc = tgt;
      void'(q.pop_front());
    end
  endtask

  // Run one whole instruction, optionally stalling when a given cycle comes up
  task automatic run_instr(input int stall_kind, input int stall_n, input bit pl,
                           input logic [15:0] tgt);
    bit done;
    int n;
    done = 1'b0; n = 0; wr_cnt = 0;
    while (!done && n < 40) begin
      if (q.size() == 0) build();
      if (int'(q[0].kind) == stall_kind && stall_n > 0) begin
        step(1'b0, pl, tgt);
        stall_n--;
      end else begin
        done = q[0].exec;
        step(1'b1, pl, tgt);
      end
      n++;
    end
    lat = n;
  endtask

  initial begin
    logic [7:0] prog [0:18];
    int         g;
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0; ready = 1'b1; pc_load = 1'b0; pc_target = '0;
    x_idx = '0; y_idx = '0; st_data = '0;
    q.delete(); model_pc = 16'h8000; prev_ir = 8'h00;
    ea_obs = '0; wr_addr = '0; wr_data = '0; ptrl_obs = '0; ptrh_obs = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    prog = '{8'hA9, 8'h42, 8'hBD, 8'hF0, 8'h12, 8'hBD, 8'hF0, 8'h12, 8'hB5, 8'hF8,
             8'hA1, 8'hFF, 8'h9D, 8'h00, 8'h20, 8'hAD, 8'h34, 8'h12, 8'hEA};
    for (int i = 0; i < 19; i++) mem[16'h8000 + 16'(i)] = prog[i];
    mem[16'h1234] = 8'hA1; mem[16'h1235] = 8'hFF;
    mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;

    #12;
    chk("rst_addr", 32'(addr), 32'h8000);
    chk("rst_sync", 32'(sync), 32'h1);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ea", 32'(ea), 32'h0);
    chk("rst_op_data", 32'(op_data), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_instr(K_NONE, 0, 1'b0, 16'h0);                       // A9 42
    chk("lda_imm_lat", 32'(lat), 32'd2);
    chk("lda_imm_data", 32'(ea_obs == ea_obs ? op_data : 8'h00), 32'h0);
    chk("lda_next_fetch", 32'(addr), 32'h8002);

    x_idx = 8'h20; run_instr(K_NONE, 0, 1'b0, 16'h0);        // BD F0 12, carry
    chk("absx_cross_ea", 32'(ea_obs), 32'h1310);
    chk("absx_cross_lat", 32'(lat), 32'd5);
    x_idx = 8'h05; run_instr(K_NONE, 0, 1'b0, 16'h0);
    chk("absx_nocross_ea", 32'(ea_obs), 32'h12F5);
    chk("absx_nocross_lat", 32'(lat), 32'd4);

    x_idx = 8'h10; run_instr(K_NONE, 0, 1'b0, 16'h0);        // B5 F8
    chk("zpx_wrap_ea", 32'(ea_obs), 32'h0008);
    chk("zpx_lat", 32'(lat), 32'd4);

    x_idx = 8'h00; run_instr(K_NONE, 0, 1'b0, 16'h0);        // A1 FF
    chk("indx_ptrl", 32'(ptrl_obs), 32'h00FF);
    chk("indx_ptrh", 32'(ptrh_obs), 32'h0000);
    chk("indx_ea", 32'(ea_obs), 32'h1234);
    chk("indx_lat", 32'(lat), 32'd6);

    st_data = 8'h5A; run_instr(K_NONE, 0, 1'b0, 16'h0);      // 9D 00 20
    chk("sta_lat", 32'(lat), 32'd5);
    chk("sta_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("sta_wr_addr", 32'(wr_addr), 32'h2000);
    chk("sta_wr_data", 32'(wr_data), 32'h5A);

    run_instr(K_ABSH, 3, 1'b0, 16'h0);                       // AD 34 12, stalled
    chk("abs_stall_lat", 32'(lat), 32'd7);
    chk("abs_stall_ea", 32'(ea_obs), 32'h1234);

    run_instr(K_NONE, 0, 1'b1, 16'h1234);                    // EA + redirect
    chk("jump_fetch_addr", 32'(addr), 32'h1234);
    chk("jump_sync", 32'(sync), 32'h1);

    // A1 FF at 0x1234; reset lands in PTR_L
    g = 0;
    while ((q.size() == 0 || int'(q[0].kind) != K_PTRL) && g < 20) begin
      step(1'b1, 1'b0, 16'h0);
      g++;
    end
    chk("reach_ptrl", 32'(g < 20), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(addr), 32'h8000);
    chk("mid_rst_sync", 32'(sync), 32'h1);
    chk("mid_rst_write", 32'(write), 32'h0);
    chk("mid_rst_op_valid", 32'(op_valid), 32'h0);
    chk("mid_rst_ir", 32'(ir), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete(); model_pc = 16'h8000; prev_ir = 8'h00;
    run_instr(K_NONE, 0, 1'b0, 16'h0);
    chk("post_rst_lat", 32'(lat), 32'd2);

    for (int c = 0; c < 4000; c++) begin
      if (q.size() == 0) begin
        x_idx   = 8'($urandom);
        y_idx   = 8'($urandom);
        st_data = 8'($urandom);
        build();
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_addr_seq.md
# cpu_addr_seq

Parametrised instruction-fetch and addressing-mode sequencer for the 6502-style core. It owns the program counter and instruction register, and walks every operand addressing mode cycle by cycle, including zero-page wrap and the page-cross fix-up cycle. It also honours `ready` stalls and accepts PC redirects. It sits between the memory bus and the datapath: the datapath consumes `op_valid`/`op_data`/`ea` and supplies index and store data.

## Interface
- `ADDR_W`, 16: address/PC width, legal range 16..24; effective addresses are zero-extended, zero page = addresses 0..255.
- `DATA_W`, 8: bus width; only 8 is supported.
- `PC_RESET`, 0: PC value loaded on reset.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ready`  in  1  0 = stall; all state holds.
- `d_in`  in  DATA_W  read data; valid in the same cycle `addr` is presented (combinational-read memory).
- `x_idx`, `y_idx`  in  DATA_W  index registers from the datapath.
- `st_data`  in  DATA_W  store data.
- `pc_load`  in  1  redirect request; sampled only in the EXEC cycle.
- `pc_target`  in  ADDR_W  redirect target.
- `addr`  out  ADDR_W  bus address.
- `write`  out  1  store strobe.
- `d_out`  out  DATA_W  write data; equals `st_data`.
- `sync`  out  1  high in FETCH (opcode cycle).
- `ir`  out  8  current opcode.
- `op_valid`  out  1  operand ready; one cycle per instruction.
- `op_data`  out  DATA_W  operand byte.
- `ea`  out  ADDR_W  effective address.

## Operation
- Mode decode is on `{bbb,cc}`.
  - cc=01: 000 (zp,X), 001 zp, 010 imm, 011 abs, 100 (zp),Y, 101 zp,X, 110 abs,Y, 111 abs,X.
  - cc=00/10: 000 imm, 001 zp, 010 implied, 011 abs, 101 zp,X, 111 abs,X; 100 and 110 are implied.
- States:
  - FETCH: `addr`=PC; `ir`<=`d_in`; PC++.
  - ZP: `addr`=PC; zp<=`d_in`; PC++.
  - IDX: dummy cycle; zp<=(zp+X) mod 256.
  - ABS_L: `addr`=PC; ADL<=`d_in`; PC++.
  - ABS_H: `addr`=PC; ADH<=`d_in`; PC++; index added here.
  - PTR_L: `addr`=zp; ADL<=`d_in`.
  - PTR_H: `addr`=(zp+1) mod 256; ADH<=`d_in`.
  - FIX: high byte incremented.
  - EXEC: `op_valid`=1.
- Mode paths:
  - imm: FETCH→EXEC.
  - implied: FETCH→EXEC.
  - zp: FETCH→ZP→EXEC.
  - zp,X: FETCH→ZP→IDX→EXEC.
  - abs: FETCH→ABS_L→ABS_H→EXEC.
  - abs,X / abs,Y: FETCH→ABS_L→ABS_H→[FIX]→EXEC.
  - (zp,X): FETCH→ZP→IDX→PTR_L→PTR_H→EXEC.
  - (zp),Y: FETCH→ZP→PTR_L→PTR_H→[FIX]→EXEC.
- FIX rule: entered when the low-byte index add carries out. It is always entered for stores (aaa=100), regardless of carry.
- Index arithmetic: low byte = ADL+idx, 8-bit with carry. `ea` = {ADH+carry, low}, zero-extended to ADDR_W.
- EXEC by mode:
  - imm: `addr`=PC, `op_data`=`d_in`, PC++.
  - implied: `addr`=PC, `op_data`=0, no PC increment.
  - memory modes: `addr`=`ea`; `op_data`=`d_in`; `write`=1 when aaa=100.
- EXEC always proceeds to FETCH. If `pc_load`, PC<=`pc_target`; this overrides the imm increment.
- PC arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values: state=FETCH, PC=PC_RESET, `ir`=0, `ea`=0, `sync`=1, `addr`=PC_RESET, `write`=0, `op_valid`=0, `op_data`=0.
- Reset asserted mid-instruction aborts it immediately. No write is issued after `reset_n` falls.
- `ready`=0 behaviour:
  - State, PC, `ir`, zp, ADL, ADH all hold.
  - `addr` stays stable.
  - `op_valid` and `write` are forced low.
  - `pc_load` is ignored.
- An instruction completes one cycle after `ready` returns.
- `op_valid` is combinational: (state==EXEC)&&`ready`. `op_data` and `ea` are valid only while `op_valid` is high.
- `sync` is high for exactly the FETCH cycle. The first FETCH after reset uses PC_RESET.
- Latency in cycles, opcode to `op_valid`, with `ready` held high:
  - imm/implied: 2.
  - zp: 3.
  - zp,X: 4.
  - abs: 4.
  - abs,X / abs,Y: 4, or 5 with FIX.
  - (zp,X): 6.
  - (zp),Y: 5, or 6 with FIX.
- Back-to-back instructions have no bubbles: the cycle after EXEC is FETCH.

## Structure
- Shared package `cpu_pkg`:
  - state enum;
  - addressing-mode enum;
  - aaa/cc opcode constants;
  - ALU mode constants (migrated from the core).
- One combinational sub-module `cpu_mode_decode`: `{bbb,cc}` → mode enum, plus an is_store flag.
- FSM, PC, and the address registers stay in `cpu_addr_seq`.

## Test plan
- Reset with PC_RESET=0x8000; memory A9 42 → FETCH `addr`=0x8000 with `sync`=1; next cycle `op_valid`=1, `op_data`=0x42; next FETCH `addr`=0x8002.
- BD F0 12 (abs,X) with X=0x20 → `ea`=0x1310, FIX taken, 5 cycles total. The same opcode with X=0x05 → `ea`=0x12F5, 4 cycles.
- B5 F8 (zp,X) with X=0x10 → `ea`=0x0008 (zero-page wrap), 4 cycles. A1 FF (zp,X) with X=0: pointer read from 0x00FF and 0x0000.
- 9D 00 20 (store, abs,X) with X=0, `st_data`=0x5A → FIX taken; `write`=1 for one cycle at `addr`=0x2000 with `d_out`=0x5A.
- `ready` low for 3 cycles during ABS_H → `addr` stable, no `op_valid`, total latency +3. `pc_load`=1 with `pc_target`=0x1234 at EXEC → next FETCH `addr`=0x1234.
- `reset_n` low during PTR_L → async return to FETCH, PC=PC_RESET, `write`=0, `op_valid`=0.
